// File: rtl/audiodac_pkg.sv
// Shared constants for the audio DAC test-tone generator: widths, amplitude and the
// quarter-wave sine table, LUT[k] = round(32767*sin(2*pi*(k+0.5)/128)).
package audiodac_pkg;

    localparam int SINEGEN_PHASE_W   = 7;
    localparam int SINEGEN_LUT_AW    = 5;
    localparam int SINEGEN_DATA_W    = 16;
    localparam int SINEGEN_AMPL      = 32767;
    localparam int SINEGEN_LUT_DEPTH = 1 << SINEGEN_LUT_AW;
    localparam int SINEGEN_PERIOD    = 1 << SINEGEN_PHASE_W;

    typedef logic [SINEGEN_PHASE_W-1:0] sinegen_phase_t;
    typedef logic [SINEGEN_DATA_W-1:0]  sinegen_sample_t;

    // Half-sample offset keeps every entry strictly inside (0, SINEGEN_AMPL).
    localparam sinegen_sample_t SINEGEN_QTR_LUT [SINEGEN_LUT_DEPTH] = '{
        16'd804,   16'd2410,  16'd4011,  16'd5602,
        16'd7179,  16'd8739,  16'd10278, 16'd11793,
        16'd13279, 16'd14732, 16'd16151, 16'd17530,
        16'd18868, 16'd20159, 16'd21403, 16'd22594,
        16'd23731, 16'd24811, 16'd25832, 16'd26790,
        16'd27683, 16'd28510, 16'd29268, 16'd29956,
        16'd30571, 16'd31113, 16'd31580, 16'd31971,
        16'd32285, 16'd32521, 16'd32678, 16'd32757
    };

    function automatic sinegen_sample_t sinegen_negate(input sinegen_sample_t v);
        return ~v + sinegen_sample_t'(1);
    endfunction

endpackage

// File: rtl/audiodac_sine_lut.sv
// Combinational phase-to-sample map. Default: quarter-wave table with quadrant mirroring;
// AUDIODAC_SINEGEN_FULL_TABLE_EN selects a directly indexed 128-entry full-period table.
module audiodac_sine_lut
    import audiodac_pkg::*;
(
    input  logic [SINEGEN_PHASE_W-1:0] phase_i,
    output logic [SINEGEN_DATA_W-1:0]  sample_o
);

`ifdef AUDIODAC_SINEGEN_FULL_TABLE_EN
    sinegen_sample_t full_tbl [SINEGEN_PERIOD];

    // Entries are folded from the quarter table at elaboration so both builds match bit-exactly.
    for (genvar gi = 0; gi < SINEGEN_PERIOD; gi++) begin : g_full_tbl
        localparam int QUAD = gi / SINEGEN_LUT_DEPTH;
        localparam int IDX  = gi % SINEGEN_LUT_DEPTH;
        localparam sinegen_sample_t MAG = (QUAD % 2 == 0) ? SINEGEN_QTR_LUT[IDX]
                                                          : SINEGEN_QTR_LUT[SINEGEN_LUT_DEPTH-1-IDX];
        localparam sinegen_sample_t VAL = (QUAD >= 2) ? sinegen_negate(MAG) : MAG;
        assign full_tbl[gi] = VAL;
    end

    assign sample_o = full_tbl[phase_i];
`else
    logic [1:0]                quad;
    logic [SINEGEN_LUT_AW-1:0] idx;
    logic [SINEGEN_LUT_AW-1:0] addr;
    sinegen_sample_t           mag;

    always_comb begin
        quad     = phase_i[SINEGEN_PHASE_W-1:SINEGEN_LUT_AW];
        idx      = phase_i[SINEGEN_LUT_AW-1:0];
        // 31-i equals the bitwise inverse of a 5-bit index.
        addr     = quad[0] ? ~idx : idx;
        mag      = SINEGEN_QTR_LUT[addr];
        sample_o = quad[1] ? sinegen_negate(mag) : mag;
    end
`endif

endmodule

// File: rtl/audiodac_sine_gen.sv
// Built-in sine test tone: phase accumulator advanced per read strobe, registered sample out.
// Table variant chosen in audiodac_sine_lut via AUDIODAC_SINEGEN_FULL_TABLE_EN.
module audiodac_sine_gen
    import audiodac_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       data_rd_i,
    input  logic                       tst_sinegen_en,
    input  logic [3:0]                 tst_sinegen_step,
    output logic [SINEGEN_DATA_W-1:0]  data_o
);

    sinegen_phase_t  phase_q;
    sinegen_phase_t  phase_d;
    sinegen_sample_t data_q;
    sinegen_sample_t data_d;
    sinegen_sample_t lut_sample;

    audiodac_sine_lut u_lut (
        .phase_i  (phase_q),
        .sample_o (lut_sample)
    );

    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        if (!tst_sinegen_en) begin
            phase_d = '0;
            data_d  = '0;
        end else if (data_rd_i) begin
            data_d  = lut_sample;
            phase_d = phase_q + sinegen_phase_t'(tst_sinegen_step);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_audiodac_sine_gen.sv
// Scoreboard bench for audiodac_sine_gen: driver pushes expected samples from a real-valued
// sine reference model, a negedge monitor pops and compares one entry per clock.
module tb_audiodac_sine_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic        en  = 1'b0;
    logic [3:0]  step = 4'd0;
    logic [15:0] data;

    audiodac_sine_gen dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .data_rd_i        (rd),
        .tst_sinegen_en   (en),
        .tst_sinegen_step (step),
        .data_o           (data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    exp;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;
    int   m_phase  = 0;
    int   m_out    = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int ref_sine(input int p);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 128.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    function automatic int sweep_const(input int n);
        case (n)
            0:       return 804;
            32:      return 32757;
            64:      return -804;
            96:      return -32757;
            default: return 804;
        endcase
    endfunction

    // One clock of stimulus; the model result (or a fixed constant) becomes the expectation.
    task automatic drive(input logic r, input logic e, input logic d, input int s,
                         input string nm, input bit use_k, input int k);
        exp_t t;
        rst  = r;
        en   = e;
        rd   = d;
        step = 4'(s);
        if (r || !e) begin
            m_phase = 0;
            m_out   = 0;
        end else if (d) begin
            m_out   = ref_sine(m_phase);
            m_phase = (m_phase + s) % 128;
        end
        t.cyc  = cyc_cnt + 1;
        t.exp  = use_k ? k : m_out;
        t.name = nm;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
                exp_t t;
                t = sb_q.pop_front();
                checks++;
                if (data !== 16'(t.exp)) begin
                    failures++;
                    $display("FAIL %s: data_o=%0d required=%0d", t.name, $signed(data), t.exp);
                end else begin
                    $display("txn %0d %s data_o=%0d ok", checks, t.name, $signed(data));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, "reset", 1, 0);
        drive(0, 1, 0, 1, "en_idle", 1, 0);
        drive(0, 1, 0, 1, "en_idle", 1, 0);
        drive(0, 1, 1, 1, "first_read", 1, 804);

        // Full step-1 period plus one wrap sample.
        drive(0, 0, 0, 1, "restart", 1, 0);
        for (int n = 0; n <= 128; n++)
            drive(0, 1, 1, 1, "step1_sweep", (n % 32) == 0, sweep_const(n));

        drive(0, 1, 1, 2,  "step2",  0, 0);
        for (int n = 0; n < 66; n++)  drive(0, 1, 1, 2,  "step2",  0, 0);
        for (int n = 0; n < 34; n++)  drive(0, 1, 1, 4,  "step4",  0, 0);
        for (int n = 0; n < 18; n++)  drive(0, 1, 1, 8,  "step8",  0, 0);
        for (int n = 0; n < 130; n++) drive(0, 1, 1, 15, "step15", 0, 0);

        drive(0, 0, 1, 15, "en_fall", 1, 0);
        drive(0, 1, 0, 3, "reen_idle", 1, 0);
        drive(0, 1, 1, 3, "reen_read", 1, 804);
        for (int n = 0; n < 5; n++)  drive(0, 1, 1, 3, "tone", 0, 0);
        for (int n = 0; n < 10; n++) drive(0, 1, 0, 3, "hold", 0, 0);
        drive(0, 1, 1, 3, "after_hold", 0, 0);
        for (int n = 0; n < 5; n++)  drive(0, 1, 1, 0, "step0", 0, 0);

        drive(1, 1, 1, 5, "rst_mid", 1, 0);
        drive(0, 1, 1, 5, "rst_release", 1, 804);

        for (int n = 0; n < 1500; n++) begin
            logic r, e, d;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 95);
            d = ($urandom_range(0, 99) < 70);
            drive(r, e, d, int'($urandom_range(0, 15)), "random", 0, 0);
        end
        rd = 1'b0;

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
